// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - multicycle RV32 control FSM with parameterised memory wait states
// Optional MC_ILLEGAL_TRAP_EN: unknown opcodes park the FSM in TRAP with illegal=1 until reset.
module multicycle_control_fsm #(
    parameter int WAIT_CYCLES = 0,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic       mem_ready,
    output logic       PCUpdate,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       MemRead,
    output logic       AdrSrc,
    output logic       Branch,
    output logic       illegal,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [2:0] ImmSrc,
    output logic [3:0] state_o
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_LUI      = 4'd12,
        S_TRAP     = 4'd15
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [CNT_W-1:0] WAIT_C = CNT_W'(WAIT_CYCLES);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    state_t           w_next;
    logic             w_mem_state;
    logic             w_done;

    assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEMREAD) || (r_state == S_MEMWRITE);
    assign w_done      = (r_cnt == WAIT_C) && mem_ready;
    assign state_o     = r_state;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:    if (w_done) w_next = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: w_next = S_MEMADR;
                    OP_RTYPE:          w_next = S_EXECR;
                    OP_ITYPE:          w_next = S_EXECI;
                    OP_BR:             w_next = S_BRANCH;
                    OP_JAL:            w_next = S_JAL;
                    OP_JALR:           w_next = S_JALR;
                    OP_LUI:            w_next = S_LUI;
                    OP_AUIPC:          w_next = S_ALUWB;
`ifdef MC_ILLEGAL_TRAP_EN
                    default:           w_next = S_TRAP;
`else
                    default:           w_next = S_FETCH;
`endif
                endcase
            end
            S_MEMADR:   w_next = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (w_done) w_next = S_MEMWB;
            S_MEMWB:    w_next = S_FETCH;
            S_MEMWRITE: if (w_done) w_next = S_FETCH;
            S_EXECR:    w_next = S_ALUWB;
            S_EXECI:    w_next = S_ALUWB;
            S_ALUWB:    w_next = S_FETCH;
            S_BRANCH:   w_next = S_FETCH;
            S_JALR:     w_next = S_JAL;
            S_JAL:      w_next = S_ALUWB;
            S_LUI:      w_next = S_FETCH;
`ifdef MC_ILLEGAL_TRAP_EN
            S_TRAP:     w_next = S_TRAP;
`else
            S_TRAP:     w_next = S_FETCH;
`endif
            default:    w_next = S_FETCH;
        endcase
    end

    // Counter restarts on every state change so each memory state sees a full wait window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state) begin
                r_cnt <= '0;
            end else if (w_mem_state && (r_cnt != WAIT_C)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        PCUpdate  = 1'b0;
        IRWrite   = 1'b0;
        RegWrite  = 1'b0;
        MemWrite  = 1'b0;
        MemRead   = 1'b0;
        AdrSrc    = 1'b0;
        Branch    = 1'b0;
        illegal   = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ALUOp     = 2'b00;
        case (r_state)
            S_FETCH: begin
                MemRead   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = w_done;
                PCUpdate  = w_done;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD: begin
                AdrSrc  = 1'b1;
                MemRead = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b10;
            end
            S_EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b10;
            end
            S_ALUWB:  RegWrite = 1'b1;
            S_BRANCH: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b01;
                Branch  = 1'b1;
            end
            S_JALR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_JAL: begin
                ALUSrcA  = 2'b01;
                ALUSrcB  = 2'b10;
                PCUpdate = 1'b1;
            end
            S_LUI: begin
                ResultSrc = 2'b11;
                RegWrite  = 1'b1;
            end
`ifdef MC_ILLEGAL_TRAP_EN
            S_TRAP:   illegal = 1'b1;
`endif
            default: ;
        endcase
        // Reset parks the FSM in FETCH; suppress its side-effecting strobes until released.
        if (!rst_n) begin
            PCUpdate = 1'b0;
            IRWrite  = 1'b0;
            RegWrite = 1'b0;
            MemWrite = 1'b0;
            MemRead  = 1'b0;
            Branch   = 1'b0;
            illegal  = 1'b0;
        end
    end

    always_comb begin
        case (op)
            OP_LOAD, OP_ITYPE, OP_JALR: ImmSrc = 3'b000;
            OP_STORE:                   ImmSrc = 3'b001;
            OP_BR:                      ImmSrc = 3'b010;
            OP_JAL:                     ImmSrc = 3'b011;
            OP_LUI, OP_AUIPC:           ImmSrc = 3'b100;
            default:                    ImmSrc = 3'b000;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb/tb_multicycle_control_fsm.sv - self-checking bench for multicycle_control_fsm (WAIT_CYCLES 0/3/2)
module tb_multicycle_control_fsm;

    typedef int q_t[$];
    typedef struct {
        logic [6:0]  op;
        logic [2:0]  imm;
        int          n;
        logic [23:0] seq;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n [3];
    logic [6:0]  op    [3];
    logic        mr    [3];
    wire  [15:0] ctl   [3];
    wire  [2:0]  imm   [3];
    wire  [3:0]  st    [3];

    int   n_chk = 0;
    int   n_err = 0;
    vec_t tv [9];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic       w_pcu, w_irw, w_rw, w_mw, w_mrd, w_adr, w_br, w_ill;
        logic [1:0] w_rs, w_asa, w_asb, w_aop;
        multicycle_control_fsm #(
            .WAIT_CYCLES((g == 0) ? 0 : ((g == 1) ? 3 : 2)),
            .CNT_W      (8)
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n[g]),
            .op       (op[g]),
            .mem_ready(mr[g]),
            .PCUpdate (w_pcu),
            .IRWrite  (w_irw),
            .RegWrite (w_rw),
            .MemWrite (w_mw),
            .MemRead  (w_mrd),
            .AdrSrc   (w_adr),
            .Branch   (w_br),
            .illegal  (w_ill),
            .ResultSrc(w_rs),
            .ALUSrcA  (w_asa),
            .ALUSrcB  (w_asb),
            .ALUOp    (w_aop),
            .ImmSrc   (imm[g]),
            .state_o  (st[g])
        );
        assign ctl[g] = {w_pcu, w_irw, w_rw, w_mw, w_mrd, w_adr, w_br, w_ill, w_rs, w_asa, w_asb, w_aop};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] mk(input bit pcu, irw, rw, mw, mrd, adr, br, ill,
                                       input int rs, asa, asb, aop);
        return {pcu, irw, rw, mw, mrd, adr, br, ill, 2'(rs), 2'(asa), 2'(asb), 2'(aop)};
    endfunction

    // Control word per state, straight from the per-state output table.
    function automatic logic [15:0] exp_ctl(input int s, input bit done);
        case (s)
            0:  return mk(done, done, 0, 0, 1, 0, 0, 0, 2, 0, 2, 0);
            1:  return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
            2:  return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0);
            3:  return mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
            4:  return mk(0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
            5:  return mk(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
            6:  return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 2);
            7:  return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 2);
            8:  return mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            9:  return mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 2, 0, 1);
            10: return mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0);
            11: return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0);
            12: return mk(0, 0, 1, 0, 0, 0, 0, 0, 3, 0, 0, 0);
            15: return mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
            default: return 16'hFFFF;
        endcase
    endfunction

    function automatic logic [15:0] rstv();
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 2, 0);
    endfunction

    function automatic logic [2:0] exp_imm(input logic [6:0] o);
        case (o)
            7'b0000011, 7'b0010011, 7'b1100111: return 3'd0;
            7'b0100011:                         return 3'd1;
            7'b1100011:                         return 3'd2;
            7'b1101111:                         return 3'd3;
            7'b0110111, 7'b0010111:             return 3'd4;
            default:                            return 3'd0;
        endcase
    endfunction

    function automatic bit is_mem(input int s);
        return (s == 0) || (s == 3) || (s == 5);
    endfunction

    // Whole-instruction state path, looked up from the vector table.
    function automatic q_t route(input logic [6:0] o);
        q_t q;
        logic [23:0] sq;
        for (int e = 0; e < 9; e++) begin
            if (tv[e].op == o) begin
                sq = tv[e].seq;
                for (int i = 0; i < tv[e].n; i++) q.push_back(int'(sq[4*i +: 4]));
                return q;
            end
        end
        q.push_back(0);
        q.push_back(1);
`ifdef MC_ILLEGAL_TRAP_EN
        q.push_back(15);
`endif
        return q;
    endfunction

    function automatic logic [6:0] pick_op();
        if ($urandom_range(0, 7) == 0) return 7'($urandom);
        return tv[$urandom_range(0, 8)].op;
    endfunction

    // Entered and left at a falling edge; the caller's first check is the fresh FETCH cycle.
    task automatic do_reset(input int k);
        rst_n[k] = 1'b0;
        op[k]    = 7'($urandom);
        mr[k]    = 1'b1;
        #1;
        chk("rst_state", 32'(st[k]), 0);
        chk("rst_ctl", 32'(ctl[k]), 32'(rstv()));
        @(negedge clk);
        @(negedge clk);
        rst_n[k] = 1'b1;
    endtask

    task automatic run_random(input int k, input int w, input int ncyc);
        q_t         rq;
        int         idx, cnt, s;
        bit         done;
        logic [6:0] co;
        do_reset(k);
        co  = pick_op();
        rq  = route(co);
        idx = 0;
        cnt = 0;
        for (int c = 0; c < ncyc; c++) begin
            s     = rq[idx];
            op[k] = co;
            mr[k] = ($urandom_range(0, 3) != 0);
            #1;
            done = is_mem(s) && (cnt == w) && mr[k];
            chk("rnd_state", 32'(st[k]), s);
            chk("rnd_ctl", 32'(ctl[k]), 32'(exp_ctl(s, done)));
            chk("rnd_imm", 32'(imm[k]), 32'(exp_imm(co)));
            if (s == 15) begin
            end else if (is_mem(s) && !done) begin
                if (cnt < w) cnt++;
            end else begin
                idx++;
                cnt = 0;
                if (idx >= rq.size()) begin
                    co  = pick_op();
                    rq  = route(co);
                    idx = 0;
                end
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int n, irw_n, s;
        tv[0] = '{7'b0110011, 3'd0, 4, 24'h008610};
        tv[1] = '{7'b0010011, 3'd0, 4, 24'h008710};
        tv[2] = '{7'b0000011, 3'd0, 5, 24'h043210};
        tv[3] = '{7'b0100011, 3'd1, 4, 24'h005210};
        tv[4] = '{7'b1100011, 3'd2, 3, 24'h000910};
        tv[5] = '{7'b1101111, 3'd3, 4, 24'h008A10};
        tv[6] = '{7'b1100111, 3'd0, 5, 24'h08AB10};
        tv[7] = '{7'b0110111, 3'd4, 3, 24'h000C10};
        tv[8] = '{7'b0010111, 3'd4, 3, 24'h000810};
        for (int k = 0; k < 3; k++) begin
            rst_n[k] = 1'b0;
            op[k]    = 7'd0;
            mr[k]    = 1'b0;
        end
        @(negedge clk);

        // Table: every opcode's state path on the zero-wait instance.
        do_reset(0);
        for (int e = 0; e < 9; e++) begin
            for (int i = 0; i < tv[e].n; i++) begin
                op[0] = tv[e].op;
                mr[0] = 1'b1;
                #1;
                s = int'(tv[e].seq[4*i +: 4]);
                chk("tbl_state", 32'(st[0]), s);
                chk("tbl_imm", 32'(imm[0]), 32'(tv[e].imm));
                chk("tbl_ctl", 32'(ctl[0]), 32'(exp_ctl(s, is_mem(s))));
                @(negedge clk);
            end
        end
        #1;
        chk("tbl_final_fetch", 32'(st[0]), 0);
        @(negedge clk);

        // Load with WAIT_CYCLES=3 and a late mem_ready on FETCH.
        do_reset(1);
        irw_n = 0;
        for (int c = 0; c < 5; c++) begin
            op[1] = 7'b0000011;
            mr[1] = (c == 4);
            #1;
            chk("w3_fetch_hold", 32'(st[1]), 0);
            irw_n += int'(ctl[1][14]);
            @(negedge clk);
        end
        chk("w3_irwrite_pulse", irw_n, 1);
        #1;
        chk("w3_decode", 32'(st[1]), 1);
        @(negedge clk);
        #1;
        chk("w3_memadr", 32'(st[1]), 2);
        @(negedge clk);
        n = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (st[1] != 4'd3) break;
            n++;
            @(negedge clk);
        end
        chk("w3_memread_len", n, 4);
        chk("w3_memwb_state", 32'(st[1]), 4);
        chk("w3_memwb_regwrite", 32'(ctl[1][13]), 1);
        chk("w3_memwb_resultsrc", 32'(ctl[1][7:6]), 1);
        @(negedge clk);

        // Unknown opcode.
        do_reset(0);
        op[0] = 7'b0000000;
        mr[0] = 1'b1;
        #1;
        chk("ill_fetch", 32'(st[0]), 0);
        @(negedge clk);
        #1;
        chk("ill_decode", 32'(st[0]), 1);
        @(negedge clk);
`ifdef MC_ILLEGAL_TRAP_EN
        for (int c = 0; c < 10; c++) begin
            #1;
            chk("ill_trap_state", 32'(st[0]), 15);
            chk("ill_trap_ctl", 32'(ctl[0]), 32'(exp_ctl(15, 1'b0)));
            @(negedge clk);
        end
`else
        #1;
        chk("ill_back_to_fetch", 32'(st[0]), 0);
        chk("ill_flag_low", 32'(ctl[0][8]), 0);
        @(negedge clk);
`endif

        // Reset asserted in the middle of a MEMWRITE with WAIT_CYCLES=2.
        do_reset(2);
        for (int c = 0; c < 20; c++) begin
            op[2] = 7'b0100011;
            mr[2] = 1'b1;
            #1;
            if (st[2] == 4'd5) break;
            @(negedge clk);
        end
        chk("w2_memwrite_reached", 32'(st[2]), 5);
        chk("w2_memwrite_strobe", 32'(ctl[2][12]), 1);
        mr[2] = 1'b0;
        #1;
        rst_n[2] = 1'b0;
        #1;
        chk("w2_rst_memwrite_drop", 32'(ctl[2][12]), 0);
        chk("w2_rst_state", 32'(st[2]), 0);
        chk("w2_rst_ctl", 32'(ctl[2]), 32'(rstv()));
        @(negedge clk);
        @(negedge clk);
        rst_n[2] = 1'b1;
        n = 0;
        for (int c = 0; c < 20; c++) begin
            mr[2] = 1'b1;
            #1;
            if (st[2] != 4'd0) break;
            n++;
            @(negedge clk);
        end
        chk("w2_refetch_len", n, 3);
        @(negedge clk);

        run_random(0, 0, 300);
        run_random(1, 3, 400);
        run_random(2, 2, 400);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
